// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-access stage: load/store op codes, FSM encoding
// and small op-decoding helpers.
package mem_ctrl_pkg;

    localparam logic        RstEnable = 1'b0;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SzByte = 2'b00,
        SzHalf = 2'b01,
        SzWord = 2'b10
    } size_e;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic is_signed_load(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LH_OP};
    endfunction

    function automatic size_e op_size(input logic [7:0] op);
        size_e sz;
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sz = SzByte;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sz = SzHalf;
            default:                          sz = SzWord;
        endcase
        return sz;
    endfunction

    function automatic logic lane_aligned(input logic [7:0] op, input logic [1:0] lane);
        logic ok;
        case (op_size(op))
            SzHalf:  ok = ~lane[0];
            SzWord:  ok = (lane == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Data-bus request/acknowledge interface between the memory stage and the data RAM.
interface mem_ctrl_if #(
    parameter int unsigned AW = 32
) ();

    logic          ram_ce_o;
    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [3:0]    ram_sel_o;
    logic [31:0]   ram_data_o;
    logic [31:0]   ram_data_i;
    logic          ram_ack_i;

    modport master (
        output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
        input  ram_data_i, ram_ack_i
    );

    modport slave (
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
        output ram_data_i, ram_ack_i
    );

endinterface

// File: rtl/mem_lane_ext.sv
// Big-endian sub-word lane logic: byte-lane select, load extraction with sign/zero
// extension, and store-data replication into every lane of the access size.
module mem_lane_ext
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [7:0]  op_i,
    input  logic [31:0] load_word_i,
    input  logic [31:0] store_word_i,
    output logic [3:0]  sel_o,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    always_comb begin
        // Lane 0 is the most significant byte of the bus word.
        unique case (lane_i)
            2'b00:   byte_v = load_word_i[31:24];
            2'b01:   byte_v = load_word_i[23:16];
            2'b10:   byte_v = load_word_i[15:8];
            default: byte_v = load_word_i[7:0];
        endcase
        half_v  = lane_i[1] ? load_word_i[15:0] : load_word_i[31:16];
        sext    = is_signed_load(op_i);

        sel_o   = 4'b1111;
        load_o  = load_word_i;
        store_o = store_word_i;
        case (op_size(op_i))
            SzByte: begin
                sel_o   = 4'b1000 >> lane_i;
                load_o  = {{24{sext & byte_v[7]}}, byte_v};
                store_o = {4{store_word_i[7:0]}};
            end
            SzHalf: begin
                sel_o   = lane_i[1] ? 4'b0011 : 4'b1100;
                load_o  = {{16{sext & half_v[15]}}, half_v};
                store_o = {2{store_word_i[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory-access pipeline stage: passes ALU results through and runs one outstanding
// req/ack data-bus access per load/store, stalling the pipeline until it resolves.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned AW      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_reg2,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq,
    output logic        exc_align_o,
    output logic        exc_bus_o,
    mem_ctrl_if.master  bus
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic [7:0]    op_q, op_d;
    logic [1:0]    lane_q, lane_d;
    logic          tout_q, tout_d;
    logic          exc_bus_q, exc_bus_d;
    logic          ce_q, ce_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   sdata_q, sdata_d;

    logic          mem_op;
    logic [7:0]    ext_op;
    logic [1:0]    ext_lane;
    logic [3:0]    ext_sel;
    logic [31:0]   ext_load;
    logic [31:0]   ext_store;

    assign mem_op   = is_load(mem_aluop) | is_store(mem_aluop);
    // Issue decodes the live inputs; DONE decodes the op captured at issue.
    assign ext_op   = (state_q == StIdle) ? mem_aluop : op_q;
    assign ext_lane = (state_q == StIdle) ? mem_addr[1:0] : lane_q;

    mem_lane_ext u_lane (
        .lane_i       (ext_lane),
        .op_i         (ext_op),
        .load_word_i  (data_q),
        .store_word_i (mem_reg2),
        .sel_o        (ext_sel),
        .load_o       (ext_load),
        .store_o      (ext_store)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_q    <= ZeroWord;
            op_q      <= '0;
            lane_q    <= '0;
            tout_q    <= 1'b0;
            exc_bus_q <= 1'b0;
            ce_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            sel_q     <= '0;
            sdata_q   <= ZeroWord;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            op_q      <= op_d;
            lane_q    <= lane_d;
            tout_q    <= tout_d;
            exc_bus_q <= exc_bus_d;
            ce_q      <= ce_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            sdata_q   <= sdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        op_d        = op_q;
        lane_d      = lane_q;
        tout_d      = tout_q;
        exc_bus_d   = 1'b0;
        ce_d        = ce_q;
        we_d        = we_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        sdata_d     = sdata_q;
        wd_o        = mem_wd;
        wreg_o      = mem_wreg;
        wdata_o     = mem_wdata;
        stallreq    = 1'b0;
        exc_align_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    wreg_o = 1'b0;
                    if (!lane_aligned(mem_aluop, mem_addr[1:0])) begin
                        exc_align_o = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                        state_d  = StBusy;
                        cnt_d    = '0;
                        op_d     = mem_aluop;
                        lane_d   = mem_addr[1:0];
                        tout_d   = 1'b0;
                        ce_d     = 1'b1;
                        we_d     = is_store(mem_aluop);
                        addr_d   = AW'({mem_addr[31:2], 2'b00});
                        sel_d    = ext_sel;
                        sdata_d  = ext_store;
                    end
                end
            end
            StBusy: begin
                wreg_o   = 1'b0;
                stallreq = 1'b1;
                cnt_d    = cnt_q + 8'd1;
                if (bus.ram_ack_i) begin
                    data_d  = bus.ram_data_i;
                    ce_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    ce_d      = 1'b0;
                    we_d      = 1'b0;
                    tout_d    = 1'b1;
                    exc_bus_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (is_load(op_q) && !tout_q) begin
                    wdata_o = ext_load;
                end else begin
                    wreg_o = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (rst == RstEnable) begin
            wd_o        = '0;
            wreg_o      = 1'b0;
            wdata_o     = ZeroWord;
            stallreq    = 1'b0;
            exc_align_o = 1'b0;
        end
    end

    assign exc_bus_o      = exc_bus_q;
    assign bus.ram_ce_o   = ce_q;
    assign bus.ram_we_o   = we_q;
    assign bus.ram_addr_o = addr_q;
    assign bus.ram_sel_o  = sel_q;
    assign bus.ram_data_o = sdata_q;

endmodule
